sdram_command: RTL and testbench

//  SDRAM command sequencer; sits directly downstream of the control interface.

---
 rtl/sdram_command.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_sdram_command.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_command.sv
// rtl/sdram_command.sv - SDRAM command sequencer: turns decoded host/init requests into timed SDRAM pin commands
//
// Purpose
//   Sits downstream of the control interface. In IDLE it picks one request per cycle
//   (INIT_REQ > PRECHARGE > LOAD_MODE > REFRESH > REF_REQ > READA > WRITEA) and walks
//   the matching command sequence, timing every wait with one shared down-counter.
//   Host accesses are one burst with auto-precharge.
//
// Ports
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_nop, i_reada, i_writea       decoded host command levels (held until o_cm_ack)
//   i_refresh, i_precharge,
//   i_load_mode                    one-cycle init-sequence pulses
//   i_saddr                        access address {bank, row, col}
//   i_ref_req                      periodic refresh request (held until o_ref_ack)
//   i_init_req                     power-up hold-off, forces NOP while high
//   o_cm_ack, o_ref_ack            one-cycle acknowledge pulses
//   o_sa, o_ba                     SDRAM address / bank pins
//   o_cs_n, o_ras_n, o_cas_n, o_we_n  SDRAM command pins
//   o_cke                          clock enable
//   o_oe                           write-data drive window
//   o_rd_valid                     read data present on DQ this cycle

module sdram_command #(
    parameter int          ASIZE     = 23,
    parameter int          ROWSIZE   = 12,
    parameter int          COLSIZE   = 9,
    parameter int          T_RCD     = 3,
    parameter int          T_RP      = 3,
    parameter int          T_RFC     = 7,
    parameter int          T_MRD     = 2,
    parameter int          T_WR      = 2,
    parameter int          CAS_LAT   = 3,
    parameter int          BURST_LEN = 8,
    parameter logic [11:0] MODE_REG  = 12'h033
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_nop,
    input  logic               i_reada,
    input  logic               i_writea,
    input  logic               i_refresh,
    input  logic               i_precharge,
    input  logic               i_load_mode,
    input  logic [ASIZE-1:0]   i_saddr,
    input  logic               i_ref_req,
    input  logic               i_init_req,
    output logic               o_cm_ack,
    output logic               o_ref_ack,
    output logic [ROWSIZE-1:0] o_sa,
    output logic [1:0]         o_ba,
    output logic               o_cs_n,
    output logic               o_ras_n,
    output logic               o_cas_n,
    output logic               o_we_n,
    output logic               o_cke,
    output logic               o_oe,
    output logic               o_rd_valid
);

    localparam int CW = 6;

    // {CS_N, RAS_N, CAS_N, WE_N}
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_LMR = 4'b0000;

    // Burst states cover the whole tail of the access (data phase plus the
    // auto-precharge recovery), counted from the RD/WR command cycle.
    localparam logic [CW-1:0] L_RCD    = CW'(T_RCD);
    localparam logic [CW-1:0] L_RP     = CW'(T_RP);
    localparam logic [CW-1:0] L_RFC    = CW'(T_RFC);
    localparam logic [CW-1:0] L_MRD    = CW'(T_MRD);
    localparam logic [CW-1:0] L_RD     = CW'(CAS_LAT + BURST_LEN + T_RP - 1);
    localparam logic [CW-1:0] L_WR     = CW'(BURST_LEN + T_WR + T_RP);
    // Outputs are registered, so windows are decoded from the counter value one
    // cycle ahead of the cycle in which they appear on the pins.
    localparam logic [CW-1:0] L_RV_LO  = CW'(T_RP + 1);
    localparam logic [CW-1:0] L_RV_HI  = CW'(T_RP + BURST_LEN);
    localparam logic [CW-1:0] L_OE_MIN = CW'(T_WR + T_RP + 2);
    localparam logic [CW-1:0] L_ONE    = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACT_WAIT,
        S_RD_BURST,
        S_WR_BURST,
        S_PRE_WAIT,
        S_REF_WAIT,
        S_MRD_WAIT
    } state_t;

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [3:0]           r_cmd;
    logic [ROWSIZE-1:0]   r_sa;
    logic [1:0]           r_ba;
    logic                 r_cm_ack;
    logic                 r_ref_ack;
    logic                 r_oe;
    logic                 r_rd_valid;
    logic                 r_cke;
    logic                 r_is_read;
    logic [1:0]           r_bank;
    logic [COLSIZE-1:0]   r_col;

    state_t               w_state_nxt;
    logic [CW-1:0]        w_cnt_nxt;
    logic [3:0]           w_cmd_nxt;
    logic [ROWSIZE-1:0]   w_sa_nxt;
    logic [1:0]           w_ba_nxt;
    logic                 w_cm_ack_nxt;
    logic                 w_ref_ack_nxt;
    logic                 w_oe_nxt;
    logic                 w_rd_valid_nxt;
    logic                 w_is_read_nxt;
    logic [1:0]           w_bank_nxt;
    logic [COLSIZE-1:0]   w_col_nxt;

    logic [1:0]           w_in_bank;
    logic [ROWSIZE-1:0]   w_in_row;
    logic [COLSIZE-1:0]   w_in_col;
    logic                 w_host_req;
    logic                 w_cnt_last;

    assign w_in_col   = i_saddr[COLSIZE-1:0];
    assign w_in_row   = i_saddr[COLSIZE +: ROWSIZE];
    assign w_in_bank  = i_saddr[ASIZE-1 -: 2];
    // An explicit NOP from the decoder suppresses any stray access level.
    assign w_host_req = !i_nop && (i_reada || i_writea);
    assign w_cnt_last = (r_cnt == L_ONE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_cmd      <= CMD_NOP;
            r_sa       <= '0;
            r_ba       <= '0;
            r_cm_ack   <= 1'b0;
            r_ref_ack  <= 1'b0;
            r_oe       <= 1'b0;
            r_rd_valid <= 1'b0;
            r_cke      <= 1'b1;
            r_is_read  <= 1'b0;
            r_bank     <= '0;
            r_col      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_cmd      <= w_cmd_nxt;
            r_sa       <= w_sa_nxt;
            r_ba       <= w_ba_nxt;
            r_cm_ack   <= w_cm_ack_nxt;
            r_ref_ack  <= w_ref_ack_nxt;
            r_oe       <= w_oe_nxt;
            r_rd_valid <= w_rd_valid_nxt;
            r_cke      <= 1'b1;
            r_is_read  <= w_is_read_nxt;
            r_bank     <= w_bank_nxt;
            r_col      <= w_col_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_cmd_nxt      = CMD_NOP;
        w_sa_nxt       = '0;
        w_ba_nxt       = '0;
        w_cm_ack_nxt   = 1'b0;
        w_ref_ack_nxt  = 1'b0;
        w_oe_nxt       = 1'b0;
        w_rd_valid_nxt = 1'b0;
        w_is_read_nxt  = r_is_read;
        w_bank_nxt     = r_bank;
        w_col_nxt      = r_col;

        case (r_state)
            S_IDLE: begin
                if (i_init_req) begin
                    w_state_nxt = S_IDLE;
                end else if (i_precharge) begin
                    w_cmd_nxt    = CMD_PRE;
                    w_sa_nxt[10] = 1'b1;
                    w_state_nxt  = S_PRE_WAIT;
                    w_cnt_nxt    = L_RP;
                end else if (i_load_mode) begin
                    w_cmd_nxt   = CMD_LMR;
                    w_sa_nxt    = ROWSIZE'(MODE_REG);
                    w_state_nxt = S_MRD_WAIT;
                    w_cnt_nxt   = L_MRD;
                end else if (i_refresh || i_ref_req) begin
                    w_cmd_nxt     = CMD_REF;
                    // Only acknowledge when the periodic request is what got serviced;
                    // an init REFRESH pulse leaves REF_REQ pending for a later cycle.
                    w_ref_ack_nxt = !i_refresh;
                    w_state_nxt   = S_REF_WAIT;
                    w_cnt_nxt     = L_RFC;
                end else if (w_host_req) begin
                    w_cmd_nxt     = CMD_ACT;
                    w_sa_nxt      = w_in_row;
                    w_ba_nxt      = w_in_bank;
                    w_cm_ack_nxt  = 1'b1;
                    w_is_read_nxt = i_reada;
                    w_bank_nxt    = w_in_bank;
                    w_col_nxt     = w_in_col;
                    w_state_nxt   = S_ACT_WAIT;
                    w_cnt_nxt     = L_RCD;
                end
            end

            S_ACT_WAIT: begin
                if (w_cnt_last) begin
                    w_sa_nxt     = ROWSIZE'(r_col);
                    w_sa_nxt[10] = 1'b1;
                    w_ba_nxt     = r_bank;
                    if (r_is_read) begin
                        w_cmd_nxt   = CMD_RD;
                        w_state_nxt = S_RD_BURST;
                        w_cnt_nxt   = L_RD;
                    end else begin
                        w_cmd_nxt   = CMD_WR;
                        w_oe_nxt    = 1'b1;
                        w_state_nxt = S_WR_BURST;
                        w_cnt_nxt   = L_WR;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - L_ONE;
                end
            end

            S_RD_BURST: begin
                w_rd_valid_nxt = (r_cnt >= L_RV_LO) && (r_cnt <= L_RV_HI);
                if (w_cnt_last) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - L_ONE;
                end
            end

            S_WR_BURST: begin
                w_oe_nxt = (r_cnt >= L_OE_MIN);
                if (w_cnt_last) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - L_ONE;
                end
            end

            S_PRE_WAIT, S_REF_WAIT, S_MRD_WAIT: begin
                if (w_cnt_last) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - L_ONE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_cs_n     = r_cmd[3];
    assign o_ras_n    = r_cmd[2];
    assign o_cas_n    = r_cmd[1];
    assign o_we_n     = r_cmd[0];
    assign o_sa       = r_sa;
    assign o_ba       = r_ba;
    assign o_cm_ack   = r_cm_ack;
    assign o_ref_ack  = r_ref_ack;
    assign o_oe       = r_oe;
    assign o_rd_valid = r_rd_valid;
    assign o_cke      = r_cke;

endmodule

// File: tb/tb_sdram_command.sv
// tb/tb_sdram_command.sv - scoreboard bench for sdram_command

module tb_sdram_command;

    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_LMR = 4'b0000;

    localparam int K_NONE = 0;
    localparam int K_SA10 = 1;
    localparam int K_FULL = 2;

    logic        clk;
    logic        rst_n;
    logic        nop, reada, writea, refresh, precharge, load_mode, ref_req, init_req;
    logic [22:0] saddr;
    logic        cm_ack, ref_ack, cs_n, ras_n, cas_n, we_n, cke, oe, rd_valid;
    logic [11:0] sa;
    logic [1:0]  ba;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int          cyc;
        logic [3:0]  cmd;
        logic [11:0] sa;
        logic [1:0]  ba;
        int          chk;
        logic        cm_ack;
        logic        ref_ack;
        logic        oe;
        logic        rv;
    } exp_t;

    exp_t exp_q[$];

    sdram_command dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_nop       (nop),
        .i_reada     (reada),
        .i_writea    (writea),
        .i_refresh   (refresh),
        .i_precharge (precharge),
        .i_load_mode (load_mode),
        .i_saddr     (saddr),
        .i_ref_req   (ref_req),
        .i_init_req  (init_req),
        .o_cm_ack    (cm_ack),
        .o_ref_ack   (ref_ack),
        .o_sa        (sa),
        .o_ba        (ba),
        .o_cs_n      (cs_n),
        .o_ras_n     (ras_n),
        .o_cas_n     (cas_n),
        .o_we_n      (we_n),
        .o_cke       (cke),
        .o_oe        (oe),
        .o_rd_valid  (rd_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic push(input int c, input logic [3:0] cmd, input logic [11:0] a, input logic [1:0] b,
                        input int k, input logic ca, input logic ra, input logic o, input logic r);
        exp_t e;
        e.cyc = c; e.cmd = cmd; e.sa = a; e.ba = b; e.chk = k;
        e.cm_ack = ca; e.ref_ack = ra; e.oe = o; e.rv = r;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick(1);
    endtask

    // Scoreboard: every cycle with a command, ack, OE or RD_VALID must match the next expected event.
    always @(negedge clk) begin
        if (rst_n && ({cs_n, ras_n, cas_n, we_n} !== C_NOP || cm_ack || ref_ack || oe || rd_valid)) begin
            n_tests++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_event: observed cmd %b oe %b rv %b at cycle %0d expected none",
                       {cs_n, ras_n, cas_n, we_n}, oe, rd_valid, cyc);
            end
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("event_cycle", 32'(cyc), 32'(e.cyc));
                check("cmd", {28'd0, cs_n, ras_n, cas_n, we_n}, {28'd0, e.cmd});
                check("cm_ack", {31'd0, cm_ack}, {31'd0, e.cm_ack});
                check("ref_ack", {31'd0, ref_ack}, {31'd0, e.ref_ack});
                check("oe", {31'd0, oe}, {31'd0, e.oe});
                check("rd_valid", {31'd0, rd_valid}, {31'd0, e.rv});
                if (e.chk == K_SA10) check("sa10", {31'd0, sa[10]}, 32'd1);
                if (e.chk == K_FULL) begin
                    check("sa", {20'd0, sa}, {20'd0, e.sa});
                    check("ba", {30'd0, ba}, {30'd0, e.ba});
                end
            end
        end
    end

    initial begin
        int t;
        logic [22:0] a1, a2, a3;
        a1 = {2'd1, 12'h0AB, 9'h012};
        a2 = {2'd2, 12'hFFF, 9'h1FF};
        a3 = {2'd3, 12'h123, 9'h0FE};

        rst_n = 1'b0; nop = 1'b1; reada = 1'b0; writea = 1'b0; refresh = 1'b0;
        precharge = 1'b0; load_mode = 1'b0; ref_req = 1'b0; init_req = 1'b1; saddr = '0;
        tick(3);
        @(negedge clk);
        check("rst_pins", {28'd0, cs_n, ras_n, cas_n, we_n}, {28'd0, C_NOP});
        check("rst_cke", {31'd0, cke}, 32'd1);
        check("rst_sa", {20'd0, sa}, 32'd0);
        check("rst_ba", {30'd0, ba}, 32'd0);
        check("rst_acks", {30'd0, cm_ack, ref_ack}, 32'd0);
        check("rst_oe_rv", {30'd0, oe, rd_valid}, 32'd0);

        // Power-up hold-off: a pending READA must not be accepted.
        @(posedge clk); #1;
        rst_n = 1'b1; reada = 1'b1; nop = 1'b0; saddr = a1;
        tick(100);
        check("init_no_ack", {31'd0, cm_ack}, 32'd0);
        init_req = 1'b0; reada = 1'b0; nop = 1'b1;
        tick(1);

        t = cyc; precharge = 1'b1;
        push(t + 1, C_PRE, 12'h0, 2'd0, K_SA10, 0, 0, 0, 0);
        tick(1); precharge = 1'b0;
        wait_until(t + 4);

        // LOAD_MODE, plus a PRECHARGE pulse during MRD_WAIT that must be dropped.
        t = cyc; load_mode = 1'b1;
        push(t + 1, C_LMR, 12'h033, 2'd0, K_FULL, 0, 0, 0, 0);
        tick(1); load_mode = 1'b0; precharge = 1'b1;
        tick(1); precharge = 1'b0;
        wait_until(t + 3);

        t = cyc; refresh = 1'b1;
        push(t + 1, C_REF, 12'h0, 2'd0, K_NONE, 0, 0, 0, 0);
        tick(1); refresh = 1'b0;
        wait_until(t + 8);

        // REF_REQ and READA together: refresh first, then the access.
        t = cyc; ref_req = 1'b1; reada = 1'b1; nop = 1'b0; saddr = a1;
        push(t + 1, C_REF, 12'h0, 2'd0, K_NONE, 0, 1, 0, 0);
        push(t + 9, C_ACT, 12'h0AB, 2'd1, K_FULL, 1, 0, 0, 0);
        push(t + 12, C_RD, 12'h412, 2'd1, K_FULL, 0, 0, 0, 0);
        for (int k = 15; k <= 22; k++) push(t + k, C_NOP, 12'h0, 2'd0, K_NONE, 0, 0, 0, 1);
        tick(1); ref_req = 1'b0;
        wait_until(t + 9); reada = 1'b0; nop = 1'b1;
        wait_until(t + 25);

        // Read, with REF_REQ and a new READA raised mid-burst.
        t = cyc; reada = 1'b1; nop = 1'b0; saddr = a1;
        push(t + 1, C_ACT, 12'h0AB, 2'd1, K_FULL, 1, 0, 0, 0);
        push(t + 4, C_RD, 12'h412, 2'd1, K_FULL, 0, 0, 0, 0);
        for (int k = 7; k <= 14; k++) push(t + k, C_NOP, 12'h0, 2'd0, K_NONE, 0, 0, 0, 1);
        tick(1); reada = 1'b0; nop = 1'b1;
        wait_until(t + 8); ref_req = 1'b1;
        wait_until(t + 10); reada = 1'b1; nop = 1'b0; saddr = a2;
        push(t + 18, C_REF, 12'h0, 2'd0, K_NONE, 0, 1, 0, 0);
        push(t + 26, C_ACT, 12'hFFF, 2'd2, K_FULL, 1, 0, 0, 0);
        push(t + 29, C_RD, 12'h5FF, 2'd2, K_FULL, 0, 0, 0, 0);
        for (int k = 32; k <= 39; k++) push(t + k, C_NOP, 12'h0, 2'd0, K_NONE, 0, 0, 0, 1);
        wait_until(t + 18); ref_req = 1'b0;
        wait_until(t + 26); reada = 1'b0; nop = 1'b1;
        wait_until(t + 42);

        // Write, then READA+WRITEA together held until accepted (READA wins).
        t = cyc; writea = 1'b1; nop = 1'b0; saddr = a1;
        push(t + 1, C_ACT, 12'h0AB, 2'd1, K_FULL, 1, 0, 0, 0);
        push(t + 4, C_WR, 12'h412, 2'd1, K_FULL, 0, 0, 1, 0);
        for (int k = 5; k <= 11; k++) push(t + k, C_NOP, 12'h0, 2'd0, K_NONE, 0, 0, 1, 0);
        push(t + 18, C_ACT, 12'h123, 2'd3, K_FULL, 1, 0, 0, 0);
        push(t + 21, C_RD, 12'h4FE, 2'd3, K_FULL, 0, 0, 0, 0);
        for (int k = 24; k <= 31; k++) push(t + k, C_NOP, 12'h0, 2'd0, K_NONE, 0, 0, 0, 1);
        tick(1); writea = 1'b0;
        tick(1); reada = 1'b1; writea = 1'b1; saddr = a3;
        wait_until(t + 18); reada = 1'b0; writea = 1'b0; nop = 1'b1;
        wait_until(t + 34);

        // Reset in the middle of a write burst.
        t = cyc; writea = 1'b1; nop = 1'b0; saddr = a1;
        push(t + 1, C_ACT, 12'h0AB, 2'd1, K_FULL, 1, 0, 0, 0);
        push(t + 4, C_WR, 12'h412, 2'd1, K_FULL, 0, 0, 1, 0);
        push(t + 5, C_NOP, 12'h0, 2'd0, K_NONE, 0, 0, 1, 0);
        tick(1); writea = 1'b0; nop = 1'b1;
        wait_until(t + 6);
        check("oe_before_reset", {31'd0, oe}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_pins", {28'd0, cs_n, ras_n, cas_n, we_n}, {28'd0, C_NOP});
        check("midrst_oe", {31'd0, oe}, 32'd0);
        check("midrst_queue", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(1);

        t = cyc; writea = 1'b1; nop = 1'b0; saddr = a2;
        push(t + 1, C_ACT, 12'hFFF, 2'd2, K_FULL, 1, 0, 0, 0);
        push(t + 4, C_WR, 12'h5FF, 2'd2, K_FULL, 0, 0, 1, 0);
        for (int k = 5; k <= 11; k++) push(t + k, C_NOP, 12'h0, 2'd0, K_NONE, 0, 0, 1, 0);
        tick(1); writea = 1'b0; nop = 1'b1;
        wait_until(t + 20);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
